reg_file_seq: RTL and testbench

REG_FILE_SEQ -- requirements
Module: reg_file_seq

---
 rtl/reg_file_seq_pkg.sv | 14 +
 rtl/reg_bank_core.sv | 22 ++
 rtl/reg_file_seq.sv | 130 +++++++++++++
 tb/tb_reg_file_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_seq_pkg.sv
// Shared sizes and FSM encoding for the sequenced register file.
// Imported by the register bank and the sequencer.
package reg_file_seq_pkg;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int NREG   = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOV_RD = 2'd1,
      MOV_WR = 2'd2,
      CLR    = 2'd3
   } state_t;
endpackage

// File: rtl/reg_bank_core.sv
// Eight-register storage with a single write port.
// Every register is a flop driven straight onto the output bus.
module reg_bank_core
   import reg_file_seq_pkg::*;
(
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          we,
   input  logic [ADDR_W-1:0]             waddr,
   input  logic [DATA_W-1:0]             wdata,
   output logic [NREG-1:0][DATA_W-1:0]   regs
);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         regs <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/reg_file_seq.sv
// Register file sequencer: single writes, two-cycle moves and
// an eight-cycle clear-all, all funnelled through one write port.
module reg_file_seq
   import reg_file_seq_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              WrEn,
   input  logic [ADDR_W-1:0] WrAddr,
   input  logic [DATA_W-1:0] WrData,
   input  logic              MovEn,
   input  logic [ADDR_W-1:0] MovSrc,
   input  logic [ADDR_W-1:0] MovDst,
   input  logic              ClrEn,
   input  logic [ADDR_W-1:0] RdAddr,
   output logic [DATA_W-1:0] R0,
   output logic [DATA_W-1:0] R1,
   output logic [DATA_W-1:0] R2,
   output logic [DATA_W-1:0] R3,
   output logic [DATA_W-1:0] R4,
   output logic [DATA_W-1:0] R5,
   output logic [DATA_W-1:0] R6,
   output logic [DATA_W-1:0] R7,
   output logic [ADDR_W-1:0] Sel,
   output logic              Busy,
   output logic              Done
);

   state_t                      state, state_nxt;
   logic [ADDR_W-1:0]           src, src_nxt;
   logic [ADDR_W-1:0]           dst, dst_nxt;
   logic [ADDR_W-1:0]           cnt, cnt_nxt;
   logic [DATA_W-1:0]           temp, temp_nxt;
   logic                        done_nxt;
   logic                        we;
   logic [ADDR_W-1:0]           waddr;
   logic [DATA_W-1:0]           wdata;
   logic [NREG-1:0][DATA_W-1:0] regs;

   reg_bank_core u_bank (
      .Clk   (Clk),
      .Rst   (Rst),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .regs  (regs)
   );

   assign R0 = regs[0];
   assign R1 = regs[1];
   assign R2 = regs[2];
   assign R3 = regs[3];
   assign R4 = regs[4];
   assign R5 = regs[5];
   assign R6 = regs[6];
   assign R7 = regs[7];

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= IDLE;
         src   <= '0;
         dst   <= '0;
         cnt   <= '0;
         temp  <= '0;
         Sel   <= '0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
      end else begin
         state <= state_nxt;
         src   <= src_nxt;
         dst   <= dst_nxt;
         cnt   <= cnt_nxt;
         temp  <= temp_nxt;
         Sel   <= RdAddr;
         Busy  <= (state_nxt != IDLE);
         Done  <= done_nxt;
      end
   end

   // Commands are only sampled in IDLE; clear beats move beats write.
   always_comb begin
      state_nxt = state;
      src_nxt   = src;
      dst_nxt   = dst;
      cnt_nxt   = cnt;
      temp_nxt  = temp;
      done_nxt  = 1'b0;
      we        = 1'b0;
      waddr     = WrAddr;
      wdata     = WrData;
      unique case (state)
         IDLE: begin
            if (ClrEn) begin
               cnt_nxt   = '0;
               state_nxt = CLR;
            end else if (MovEn) begin
               src_nxt   = MovSrc;
               dst_nxt   = MovDst;
               state_nxt = MOV_RD;
            end else if (WrEn) begin
               we       = 1'b1;
               done_nxt = 1'b1;
            end
         end
         MOV_RD: begin
            temp_nxt  = regs[src];
            state_nxt = MOV_WR;
         end
         MOV_WR: begin
            we        = 1'b1;
            waddr     = dst;
            wdata     = temp;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end
         CLR: begin
            we      = 1'b1;
            waddr   = cnt;
            wdata   = '0;
            cnt_nxt = cnt + 3'd1;
            if (cnt == 3'd7) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_reg_file_seq.sv
// Scoreboard bench for reg_file_seq: a queue-of-actions model predicts
// each cycle's outputs, a monitor compares them after every edge.
module tb_reg_file_seq;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       WrEn = 1'b0, MovEn = 1'b0, ClrEn = 1'b0;
   logic [2:0] WrAddr = '0, MovSrc = '0, MovDst = '0, RdAddr = '0;
   logic [7:0] WrData = '0;
   logic [7:0] R0, R1, R2, R3, R4, R5, R6, R7;
   logic [2:0] Sel;
   logic       Busy, Done;

   reg_file_seq dut (
      .Clk(Clk), .Rst(Rst),
      .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
      .MovEn(MovEn), .MovSrc(MovSrc), .MovDst(MovDst),
      .ClrEn(ClrEn), .RdAddr(RdAddr),
      .R0(R0), .R1(R1), .R2(R2), .R3(R3),
      .R4(R4), .R5(R5), .R6(R6), .R7(R7),
      .Sel(Sel), .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [63:0] regs;
      logic [2:0]  sel;
      logic        busy;
      logic        done;
   } snap_t;

   // kind: 1 read src into temp, 2 write temp, 3 write zero
   typedef struct {
      int kind;
      int addr;
      bit last;
   } act_t;

   snap_t      exp_q[$];
   act_t       pend[$];
   logic [7:0] m[8];
   logic [7:0] mtemp;
   snap_t      mon_e;
   int         compared = 0;
   int         mismatched = 0;

   function automatic snap_t mk(logic [2:0] s, logic b, logic d);
      snap_t x;
      for (int i = 0; i < 8; i++) x.regs[i*8 +: 8] = m[i];
      x.sel  = s;
      x.busy = b;
      x.done = d;
      return x;
   endfunction

   function automatic snap_t dut_snap();
      snap_t x;
      x.regs = {R7, R6, R5, R4, R3, R2, R1, R0};
      x.sel  = Sel;
      x.busy = Busy;
      x.done = Done;
      return x;
   endfunction

   function automatic logic [7:0] mux_out();
      logic [7:0] y;
      case (Sel)
         3'd0: y = R0;
         3'd1: y = R1;
         3'd2: y = R2;
         3'd3: y = R3;
         3'd4: y = R4;
         3'd5: y = R5;
         3'd6: y = R6;
         default: y = R7;
      endcase
      return y;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic cmp(snap_t a, snap_t e);
      logic [63:0] r;
      r = e.regs;
      chk("regs", a.regs, e.regs);
      chk("sel", 64'(a.sel), 64'(e.sel));
      chk("busy", 64'(a.busy), 64'(e.busy));
      chk("done", 64'(a.done), 64'(e.done));
      chk("mux", 64'(mux_out()), 64'(r[e.sel*8 +: 8]));
   endtask

   always @(posedge Clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         cmp(dut_snap(), mon_e);
      end
   end

   task automatic step(bit wr, int wa, int wd, bit mv, int ms, int md,
                       bit cl, int ra);
      act_t a;
      bit   d;
      @(negedge Clk);
      Rst = 1'b0;
      WrEn = wr; WrAddr = wa[2:0]; WrData = wd[7:0];
      MovEn = mv; MovSrc = ms[2:0]; MovDst = md[2:0];
      ClrEn = cl; RdAddr = ra[2:0];
      d = 1'b0;
      if (pend.size() > 0) begin
         a = pend.pop_front();
         case (a.kind)
            1: mtemp = m[a.addr];
            2: m[a.addr] = mtemp;
            3: m[a.addr] = 8'h00;
            default: ;
         endcase
         d = a.last;
      end else if (cl) begin
         for (int k = 0; k < 8; k++) pend.push_back('{3, k, k == 7});
      end else if (mv) begin
         pend.push_back('{1, ms, 1'b0});
         pend.push_back('{2, md, 1'b1});
      end else if (wr) begin
         m[wa] = wd[7:0];
         d = 1'b1;
      end
      exp_q.push_back(mk(ra[2:0], pend.size() != 0, d));
   endtask

   task automatic idle(int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, $urandom_range(0, 7));
   endtask

   task automatic do_reset(int n);
      @(negedge Clk);
      Rst = 1'b1;
      WrEn = 0; MovEn = 0; ClrEn = 0; RdAddr = '0;
      for (int i = 0; i < 8; i++) m[i] = 8'h00;
      mtemp = 8'h00;
      pend.delete();
      #1;
      cmp(dut_snap(), mk(3'd0, 1'b0, 1'b0));
      exp_q.push_back(mk(3'd0, 1'b0, 1'b0));
      repeat (n - 1) begin
         @(negedge Clk);
         exp_q.push_back(mk(3'd0, 1'b0, 1'b0));
      end
   endtask

   initial begin
      do_reset(2);
      // single write
      step(1, 3, 8'h5A, 0, 0, 0, 0, 3);
      idle(2);
      // move 2 -> 6
      step(1, 2, 8'h11, 0, 0, 0, 0, 2);
      step(0, 0, 0, 1, 2, 6, 0, 6);
      idle(3);
      // self move
      step(0, 0, 0, 1, 3, 3, 0, 3);
      idle(3);
      // fill with 0xFF, then clear with a write mid-clear and a Sel sweep
      for (int i = 0; i < 8; i++) step(1, i, 8'hFF, 0, 0, 0, 0, i);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++)
         step(i == 3, 5, 8'hA5, i == 5, 1, 2, 0, i);
      idle(2);
      // all three requests at once: clear wins
      step(1, 4, 8'h77, 0, 0, 0, 0, 4);
      step(1, 1, 8'h33, 1, 4, 0, 1, 4);
      idle(9);
      // reset in the middle of a clear
      for (int i = 0; i < 8; i++) step(1, i, 8'hC0 + i, 0, 0, 0, 0, i);
      step(0, 0, 0, 0, 0, 0, 1, 7);
      idle(4);
      do_reset(2);
      step(1, 6, 8'h42, 0, 0, 0, 0, 6);
      idle(2);
      // random traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 149) == 0) do_reset(1);
         else step($urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 255), $urandom_range(0, 5) == 0,
                   $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 19) == 0, $urandom_range(0, 7));
      end
      idle(2);
      @(posedge Clk);
      #2;
      chk("drain", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
